// File: rtl/chirp_phase_gen.sv
// Linear-FM phase generator feeding sine_rom: phase accumulates a frequency word
// that itself ramps by a fixed step every sample, emitting top-M phase bits per strobe.
module chirp_phase_gen #(
  parameter int M     = 10,
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] cfg_f_start,
  input  logic [ACC_W-1:0] cfg_f_step,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             cfg_repeat,
  input  logic             sample_en,
  output logic [M-1:0]     addr,
  output logic             addr_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] phase_q, phase_d, freq_q, freq_d;
  logic [ACC_W-1:0] f_start_q, f_start_d, step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic             rpt_q, rpt_d;
  logic [M-1:0]     addr_q, addr_d;
  logic             addr_valid_q, addr_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             done_pend_q, done_pend_d;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    freq_d       = freq_q;
    f_start_d    = f_start_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    rpt_d        = rpt_q;
    addr_d       = addr_q;
    addr_valid_d = 1'b0;
    busy_d       = busy_q;
    // done trails the last-sample edge by one cycle so addr_valid and done never coincide
    done_d       = done_pend_q;
    done_pend_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          f_start_d = cfg_f_start;
          step_d    = cfg_f_step;
          len_d     = cfg_len;
          rpt_d     = cfg_repeat;
          phase_d   = '0;
          freq_d    = cfg_f_start;
          cnt_d     = '0;
          if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SWEEP;
            busy_d  = 1'b1;
          end
        end
      end
      SWEEP: begin
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (sample_en) begin
          addr_d       = phase_q[ACC_W-1 -: M];
          addr_valid_d = 1'b1;
          phase_d      = phase_q + freq_q;
          freq_d       = freq_q + step_q;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) begin
            if (rpt_q) begin
              phase_d = '0;
              freq_d  = f_start_q;
              cnt_d   = '0;
            end else begin
              state_d     = IDLE;
              busy_d      = 1'b0;
              done_pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      freq_q       <= '0;
      f_start_q    <= '0;
      step_q       <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      rpt_q        <= 1'b0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      freq_q       <= freq_d;
      f_start_q    <= f_start_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      rpt_q        <= rpt_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_pend_q  <= done_pend_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = addr_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_chirp_phase_gen.sv
// Directed bench for chirp_phase_gen: table of sweep configs with hand-computed
// addresses, plus explicit stop/start+stop/len=0/async-reset sequences.
module tb_chirp_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, sample_en = 1'b0, cfg_repeat = 1'b0;
  logic [31:0] cfg_f_start = '0, cfg_f_step = '0;
  logic [15:0] cfg_len = '0;
  logic [9:0]  addr;
  logic        addr_valid, busy, done;

  int checks = 0;
  int errors = 0;

  chirp_phase_gen #(.M(10), .ACC_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_f_start(cfg_f_start), .cfg_f_step(cfg_f_step), .cfg_len(cfg_len),
    .cfg_repeat(cfg_repeat), .sample_en(sample_en),
    .addr(addr), .addr_valid(addr_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] f_start;
    logic [31:0] step;
    logic [15:0] len;
    logic        rpt;
    int          n;
    int          exp [6];
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(logic [31:0] f, logic [31:0] s, logic [15:0] l, logic r, int n,
                              int a0, int a1, int a2, int a3, int a4, int a5);
    vec_t v;
    v.f_start = f; v.step = s; v.len = l; v.rpt = r; v.n = n;
    v.exp[0] = a0; v.exp[1] = a1; v.exp[2] = a2;
    v.exp[3] = a3; v.exp[4] = a4; v.exp[5] = a5;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [31:0] f, logic [31:0] s, logic [15:0] l, logic r, logic stp);
    cfg_f_start = f; cfg_f_step = s; cfg_len = l; cfg_repeat = r;
    start = 1'b1; stop = stp;
    tick();
    start = 1'b0; stop = 1'b0;
    // scramble cfg to show it has no effect once latched
    cfg_f_start = 32'hDEAD_BEEF; cfg_f_step = 32'h1234_5678; cfg_len = 16'd1; cfg_repeat = ~r;
  endtask

  // two idle clocks, then a one-clock strobe; outputs inspected after the strobe edge
  task automatic strobe(logic stp);
    tick();
    chk("idle_gap_no_valid", int'(addr_valid), 0);
    tick();
    sample_en = 1'b1; stop = stp;
    tick();
    sample_en = 1'b0; stop = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(32'h0100_0000, 32'h0,         16'd4, 1'b0, 4, 0, 4, 8, 12, 0, 0);
    vecs[1] = mk(32'h0,         32'h0040_0000, 16'd5, 1'b0, 5, 0, 0, 1, 3, 6, 0);
    vecs[2] = mk(32'h8000_0000, 32'h0,         16'd3, 1'b0, 3, 0, 512, 0, 0, 0, 0);
    vecs[3] = mk(32'hFFC0_0000, 32'h0040_0000, 16'd3, 1'b0, 3, 0, 1023, 1023, 0, 0, 0);
    vecs[4] = mk(32'h0100_0000, 32'h0,         16'd2, 1'b1, 6, 0, 4, 0, 4, 0, 4);

    #12;
    chk("rst_addr", int'(addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(addr_valid), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      do_start(vecs[i].f_start, vecs[i].step, vecs[i].len, vecs[i].rpt, 1'b0);
      chk($sformatf("v%0d_busy_start", i), int'(busy), 1);
      for (int k = 0; k < vecs[i].n; k++) begin
        strobe(1'b0);
        chk($sformatf("v%0d_valid_%0d", i, k), int'(addr_valid), 1);
        chk($sformatf("v%0d_addr_%0d", i, k), int'(addr), vecs[i].exp[k]);
        chk($sformatf("v%0d_done_%0d", i, k), int'(done), 0);
        if (!vecs[i].rpt && k == vecs[i].n - 1)
          chk($sformatf("v%0d_busy_last", i), int'(busy), 0);
        else
          chk($sformatf("v%0d_busy_%0d", i, k), int'(busy), 1);
      end
      if (!vecs[i].rpt) begin
        tick();
        chk($sformatf("v%0d_done_pulse", i), int'(done), 1);
        chk($sformatf("v%0d_valid_low", i), int'(addr_valid), 0);
        tick();
        chk($sformatf("v%0d_done_once", i), int'(done), 0);
      end else begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("rpt_stop_busy", int'(busy), 0);
        tick();
        chk("rpt_stop_no_done", int'(done), 0);
      end
    end

    // sample_en in IDLE is ignored and addr holds the last emitted value (4)
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    chk("idle_strobe_valid", int'(addr_valid), 0);
    chk("idle_addr_hold", int'(addr), 4);

    // stop coincident with the 3rd strobe of the repeat setup
    do_start(32'h0100_0000, 32'h0, 16'd2, 1'b1, 1'b0);
    strobe(1'b0);
    chk("stp_a0", int'(addr), 0);
    strobe(1'b0);
    chk("stp_a1", int'(addr), 4);
    strobe(1'b1);
    chk("stp_no_valid", int'(addr_valid), 0);
    chk("stp_busy", int'(busy), 0);
    chk("stp_addr_hold", int'(addr), 4);
    tick();
    chk("stp_no_done", int'(done), 0);
    tick();
    chk("stp_no_done2", int'(done), 0);

    // start and stop together in IDLE: nothing happens
    do_start(32'h0100_0000, 32'h0, 16'd4, 1'b0, 1'b1);
    chk("ss_busy", int'(busy), 0);
    chk("ss_done", int'(done), 0);
    strobe(1'b0);
    chk("ss_no_valid", int'(addr_valid), 0);
    chk("ss_busy2", int'(busy), 0);

    // zero-length sweep: done one clock after start, no busy, no address
    do_start(32'h0100_0000, 32'h0, 16'd0, 1'b0, 1'b0);
    chk("len0_done", int'(done), 1);
    chk("len0_busy", int'(busy), 0);
    chk("len0_valid", int'(addr_valid), 0);
    tick();
    chk("len0_done_once", int'(done), 0);
    strobe(1'b0);
    chk("len0_no_valid", int'(addr_valid), 0);

    // asynchronous reset mid-sweep, between clock edges
    do_start(32'h0100_0000, 32'h0, 16'd4, 1'b0, 1'b0);
    strobe(1'b0);
    strobe(1'b0);
    chk("pre_rst_addr", int'(addr), 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", int'(addr), 0);
    chk("arst_valid", int'(addr_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    do_start(32'h0100_0000, 32'h0, 16'd4, 1'b0, 1'b0);
    chk("post_rst_busy", int'(busy), 1);
    strobe(1'b0);
    chk("post_rst_a0", int'(addr), 0);
    chk("post_rst_v0", int'(addr_valid), 1);
    strobe(1'b0);
    chk("post_rst_a1", int'(addr), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chirp_phase_gen.md
Name: chirp_phase_gen

Overview:
- Linear-FM phase generator directly upstream of sine_rom in the chirp chain.
- Runs a phase accumulator whose frequency word is incremented by a fixed step every sample, giving a linear chirp.
- Drives the top M phase bits as the sine_rom address, one address per sample_en strobe.
- Provides a start/stop/busy/done handshake for the controlling sequencer.

Parameters:
- M, 10, address width; must equal sine_rom M.
- ACC_W, 32, phase accumulator, frequency word and step width; ACC_W > M.
- CNT_W, 16, sample counter width; sets the maximum sweep length.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle request to begin a sweep; honoured only in IDLE.
- stop  in  1  abort request; honoured in SWEEP.
- cfg_f_start  in  ACC_W  initial frequency word; latched at start.
- cfg_f_step  in  ACC_W  per-sample frequency increment, unsigned, mod 2^ACC_W; latched at start.
- cfg_len  in  CNT_W  samples per sweep; latched at start.
- cfg_repeat  in  1  1 = restart automatically after the last sample; latched at start.
- sample_en  in  1  sample-rate strobe, 1 clk wide.
- addr  out  M  phase address to sine_rom.
- addr_valid  out  1  1-cycle pulse; addr updated this cycle.
- busy  out  1  high while in SWEEP.
- done  out  1  1-cycle pulse when a non-repeating sweep completes.

Behaviour:
- Reset (async, any time, including mid-sweep):
  - state=IDLE; phase, freq, cnt = 0.
  - addr=0, addr_valid=0, busy=0, done=0.
- States: IDLE and SWEEP. All outputs are registered.
- IDLE behaviour:
  - start=1 and stop=0: latch all cfg_* inputs, set phase=0, freq=cfg_f_start, cnt=0.
  - If cfg_len=0: stay IDLE and pulse done next cycle; no addr_valid is produced.
  - Otherwise: go to SWEEP and set busy=1 on the same edge.
  - start=1 and stop=1 together in IDLE: stop wins; remain IDLE with no done pulse.
  - sample_en is ignored in IDLE; addr holds its last value.
- SWEEP, on each sample_en=1 with stop=0:
  - addr <= phase[ACC_W-1:ACC_W-M]; addr_valid <= 1 for one cycle.
  - phase <= phase + freq, mod 2^ACC_W.
  - freq <= freq + step, mod 2^ACC_W; freq wraparound is allowed and not flagged.
  - cnt <= cnt + 1.
  - The address for sample k equals the top M bits of (k·f_start + step·k(k−1)/2) mod 2^ACC_W.
- Last sample, i.e. sample_en while cnt = len−1:
  - Address is emitted as normal.
  - If repeat=1: reload phase=0, freq=f_start, cnt=0 and stay in SWEEP, so the next sample restarts the sweep seamlessly.
  - If repeat=0: go to IDLE and drop busy on the same edge; done pulses on the following cycle.
- SWEEP with stop=1:
  - Go to IDLE on the next edge, busy=0; no done pulse.
  - stop has priority over a simultaneous sample_en, so no addr_valid that cycle.
- start while in SWEEP is ignored. cfg_* changes during a sweep have no effect.
- Latency:
  - addr/addr_valid are valid 1 clk after sample_en.
  - sine_rom data is valid 2 clk after sample_en.
- Minimum sample_en spacing is 1 clk; back-to-back strobes are supported.

Test Plan:
- Reset, then f_start=0x0100_0000, step=0, len=4, repeat=0, start, sample_en every 3 clk:
  - addr = 0, 4, 8, 12, each with a 1-clk addr_valid.
  - busy falls with the 4th sample; done pulses once, 1 clk later.
- Chirp: f_start=0, step=0x0040_0000, len=5:
  - addr = 0, 0, 1, 3, 6.
- Wrap: f_start=0x8000_0000, step=0, len=3:
  - addr = 0, 512, 0 (phase mod 2^32).
- Repeat: len=2, f_start=0x0100_0000, step=0, repeat=1, 6 strobes:
  - addr = 0, 4, 0, 4, 0, 4; busy stays 1; no done.
- Stop and concurrent start:
  - In the same setup, assert stop together with the 3rd sample_en: no addr_valid, busy=0 next clk, no done.
  - start+stop in IDLE: stays IDLE.
- Edge cases:
  - len=0 start: done pulses 1 clk after start, busy stays 0, no addr_valid.
  - rst asserted mid-sweep: all outputs 0 immediately (asynchronous).
  - After rst release, a new start runs normally from addr 0.
